// File: rtl/cdc_bus_receiver_if.sv
// ---------------------------------------------------------------------------
// cdc_bus_receiver_if
// Bundles the REQ/ACK bus-crossing signals between a sender and the
// cdc_bus_receiver block.
//   REQ_ASYNC     sender request, asynchronous to the receiver clock
//   UNSYNC_BUS    sender data, held stable while REQ_ASYNC is high
//   ERR_CLR       clears the sticky timeout flag
//   SYNC_BUS      last captured word
//   ENABLE_PULSE  one-cycle strobe marking a SYNC_BUS update
//   ACK           handshake acknowledge back to the sender
//   ERR_FLAG      sticky "REQ held too long" flag
//   XFER_CNT      completed-capture count, wraps modulo 256
// Modports: master = sender side, slave = receiver side.
// ---------------------------------------------------------------------------
interface cdc_bus_receiver_if #(
    parameter int BUS_WIDTH = 8
);
    logic                 REQ_ASYNC;
    logic [BUS_WIDTH-1:0] UNSYNC_BUS;
    logic                 ERR_CLR;
    logic [BUS_WIDTH-1:0] SYNC_BUS;
    logic                 ENABLE_PULSE;
    logic                 ACK;
    logic                 ERR_FLAG;
    logic [7:0]           XFER_CNT;

    modport master (
        output REQ_ASYNC, UNSYNC_BUS, ERR_CLR,
        input  SYNC_BUS, ENABLE_PULSE, ACK, ERR_FLAG, XFER_CNT
    );

    modport slave (
        input  REQ_ASYNC, UNSYNC_BUS, ERR_CLR,
        output SYNC_BUS, ENABLE_PULSE, ACK, ERR_FLAG, XFER_CNT
    );
endinterface

// File: rtl/cdc_bus_receiver.sv
// ---------------------------------------------------------------------------
// cdc_bus_receiver
// Receive end of a 4-phase REQ/ACK clock-domain crossing. REQ_ASYNC is
// synchronised through NUM_STAGES flops; the sender-held bus is captured once
// per REQ high phase, announced with a one-cycle ENABLE_PULSE, and ACK is
// returned to the sender. A REQ held high too long in ACK_HI sets ERR_FLAG.
// Parameters:
//   BUS_WIDTH    width of the transferred word
//   NUM_STAGES   REQ synchroniser depth (2..4)
//   TIMEOUT_CYC  ACK_HI cycles before ERR_FLAG sets; 0 disables, max 65535
// Ports:
//   CLK   receive-domain clock
//   RST   synchronous active-low reset
//   bus   cdc_bus_receiver_if.slave (REQ_ASYNC, UNSYNC_BUS, ERR_CLR in;
//         SYNC_BUS, ENABLE_PULSE, ACK, ERR_FLAG, XFER_CNT out)
// ---------------------------------------------------------------------------
module cdc_bus_receiver #(
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_STAGES  = 2,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                  CLK,
    input  logic                  RST,
    cdc_bus_receiver_if.slave     bus
);

    // Timer value on the edge that marks the TIMEOUT_CYC-th ACK_HI cycle.
    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYC != 0);
    localparam logic [15:0] TIMEOUT_LAST = TIMEOUT_EN ? 16'(TIMEOUT_CYC - 1) : 16'd0;

    typedef enum logic {
        IDLE   = 1'b0,
        ACK_HI = 1'b1
    } state_t;

    // ---------------- REQ synchroniser ----------------
    logic [NUM_STAGES-1:0] sync_reg;
    logic [NUM_STAGES-1:0] sync_next;
    logic                  req_s;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = bus.REQ_ASYNC;
            end else begin : g_chain
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    assign req_s = sync_reg[NUM_STAGES-1];

    // ---------------- FSM and datapath ----------------
    state_t               state_reg,    state_next;
    logic [15:0]          timer_reg,    timer_next;
    logic [BUS_WIDTH-1:0] sync_bus_reg, sync_bus_next;
    logic                 pulse_reg,    pulse_next;
    logic                 ack_reg,      ack_next;
    logic                 err_reg,      err_next;
    logic [7:0]           cnt_reg,      cnt_next;
    logic                 err_set;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync_reg     <= '0;
            state_reg    <= IDLE;
            timer_reg    <= '0;
            sync_bus_reg <= '0;
            pulse_reg    <= 1'b0;
            ack_reg      <= 1'b0;
            err_reg      <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            sync_reg     <= sync_next;
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            sync_bus_reg <= sync_bus_next;
            pulse_reg    <= pulse_next;
            ack_reg      <= ack_next;
            err_reg      <= err_next;
            cnt_reg      <= cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        timer_next    = timer_reg;
        sync_bus_next = sync_bus_reg;
        pulse_next    = 1'b0;
        ack_next      = ack_reg;
        cnt_next      = cnt_reg;

        case (state_reg)
            IDLE: begin
                if (req_s) begin
                    sync_bus_next = bus.UNSYNC_BUS;
                    pulse_next    = 1'b1;
                    ack_next      = 1'b1;
                    cnt_next      = cnt_reg + 8'd1;
                    timer_next    = '0;
                    state_next    = ACK_HI;
                end
            end
            ACK_HI: begin
                if (!req_s) begin
                    ack_next   = 1'b0;
                    state_next = IDLE;
                end else if (timer_reg != 16'hFFFF) begin
                    timer_next = timer_reg + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Flag on the edge where the timer lands on the last allowed value
        // while REQ is still held, so ERR_FLAG is visible during the
        // TIMEOUT_CYC-th ACK_HI cycle. Saturation means it never re-fires.
        err_set = TIMEOUT_EN && req_s && (state_next == ACK_HI)
                  && (timer_next == TIMEOUT_LAST);

        // Set has priority over a coincident clear.
        if (err_set)
            err_next = 1'b1;
        else if (bus.ERR_CLR)
            err_next = 1'b0;
        else
            err_next = err_reg;
    end

    assign bus.SYNC_BUS     = sync_bus_reg;
    assign bus.ENABLE_PULSE = pulse_reg;
    assign bus.ACK          = ack_reg;
    assign bus.ERR_FLAG     = err_reg;
    assign bus.XFER_CNT     = cnt_reg;

endmodule

// File: tb/tb_cdc_bus_receiver.sv
// ---------------------------------------------------------------------------
// tb_cdc_bus_receiver
// Directed bench for cdc_bus_receiver. Two instances share one stimulus:
// dut_a with TIMEOUT_CYC=16 (main checks) and dut_b with TIMEOUT_CYC=0
// (timeout disabled). Inputs change 1 time unit after posedge; outputs are
// sampled at the same point, i.e. after the edge has settled.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cdc_bus_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [7:0] data;
    logic       clr;

    int n_checks = 0;
    int n_fail   = 0;

    cdc_bus_receiver_if #(.BUS_WIDTH(8)) bus_a ();
    cdc_bus_receiver_if #(.BUS_WIDTH(8)) bus_b ();

    assign bus_a.REQ_ASYNC  = req;
    assign bus_a.UNSYNC_BUS = data;
    assign bus_a.ERR_CLR    = clr;
    assign bus_b.REQ_ASYNC  = req;
    assign bus_b.UNSYNC_BUS = data;
    assign bus_b.ERR_CLR    = clr;

    cdc_bus_receiver #(.BUS_WIDTH(8), .NUM_STAGES(2), .TIMEOUT_CYC(16)) dut_a (
        .CLK (clk),
        .RST (rst),
        .bus (bus_a)
    );

    cdc_bus_receiver #(.BUS_WIDTH(8), .NUM_STAGES(2), .TIMEOUT_CYC(0)) dut_b (
        .CLK (clk),
        .RST (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise REQ with the given data and advance to the expected capture edge
    // (edge 2 after the first sample).
    task automatic raise_and_capture(input logic [7:0] d);
        data = d;
        req  = 1'b1;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        req  = 1'b1;
        data = 8'h5A;
        clr  = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if ({bus_a.SYNC_BUS, bus_a.ENABLE_PULSE, bus_a.ACK, bus_a.ERR_FLAG, bus_a.XFER_CNT} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got sync=%h pulse=%b ack=%b err=%b cnt=%0d, want all 0",
                     bus_a.SYNC_BUS, bus_a.ENABLE_PULSE, bus_a.ACK, bus_a.ERR_FLAG, bus_a.XFER_CNT);
        end
        rst = 1'b1;
        tick();  // edge 0
        tick();  // edge 1
        n_checks++;
        if (bus_a.ENABLE_PULSE !== 1'b0 || bus_a.ACK !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_early_pulse: got pulse=%b ack=%b at edge 1, want 0 0",
                     bus_a.ENABLE_PULSE, bus_a.ACK);
        end
        tick();  // edge 2
        n_checks++;
        if (bus_a.ENABLE_PULSE !== 1'b1 || bus_a.SYNC_BUS !== 8'h5A || bus_a.XFER_CNT !== 8'd1 || bus_a.ACK !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_recapture: got pulse=%b sync=%h cnt=%0d ack=%b, want 1 5a 1 1",
                     bus_a.ENABLE_PULSE, bus_a.SYNC_BUS, bus_a.XFER_CNT, bus_a.ACK);
        end
        req = 1'b0;
        tick(); tick(); tick();
        $display("reset: done, ack=%b cnt=%0d", bus_a.ACK, bus_a.XFER_CNT);
    endtask

    task automatic test_single_transfer();
        data = 8'hA5;
        req  = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus_a.ENABLE_PULSE !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: got pulse=%b at edge 1, want 0", bus_a.ENABLE_PULSE);
        end
        tick();
        n_checks++;
        if (bus_a.ENABLE_PULSE !== 1'b1 || bus_a.SYNC_BUS !== 8'hA5 || bus_a.ACK !== 1'b1 || bus_a.XFER_CNT !== 8'd2) begin
            n_fail++;
            $display("FAIL single_capture: got pulse=%b sync=%h ack=%b cnt=%0d, want 1 a5 1 2",
                     bus_a.ENABLE_PULSE, bus_a.SYNC_BUS, bus_a.ACK, bus_a.XFER_CNT);
        end
        tick();
        n_checks++;
        if (bus_a.ENABLE_PULSE !== 1'b0 || bus_a.ACK !== 1'b1) begin
            n_fail++;
            $display("FAIL single_pulse_width: got pulse=%b ack=%b, want 0 1",
                     bus_a.ENABLE_PULSE, bus_a.ACK);
        end
        req = 1'b0;
        tick();  // edge 0 of REQ low
        tick();  // edge 1
        n_checks++;
        if (bus_a.ACK !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ack_hold: got ack=%b at edge 1 after REQ fall, want 1", bus_a.ACK);
        end
        tick();  // edge 2
        n_checks++;
        if (bus_a.ACK !== 1'b0 || bus_a.SYNC_BUS !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_ack_fall: got ack=%b sync=%h, want 0 a5", bus_a.ACK, bus_a.SYNC_BUS);
        end
        data = 8'h00;
        tick(); tick(); tick();
        n_checks++;
        if (bus_a.SYNC_BUS !== 8'hA5 || bus_a.ENABLE_PULSE !== 1'b0) begin
            n_fail++;
            $display("FAIL single_hold_idle: got sync=%h pulse=%b, want a5 0",
                     bus_a.SYNC_BUS, bus_a.ENABLE_PULSE);
        end
        $display("single_transfer: sync=%h cnt=%0d", bus_a.SYNC_BUS, bus_a.XFER_CNT);
    endtask

    task automatic test_bus_change();
        raise_and_capture(8'h3C);
        n_checks++;
        if (bus_a.ENABLE_PULSE !== 1'b1 || bus_a.SYNC_BUS !== 8'h3C) begin
            n_fail++;
            $display("FAIL buschg_capture: got pulse=%b sync=%h, want 1 3c",
                     bus_a.ENABLE_PULSE, bus_a.SYNC_BUS);
        end
        data = 8'hFF;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++;
            if (bus_a.ENABLE_PULSE !== 1'b0 || bus_a.SYNC_BUS !== 8'h3C) begin
                n_fail++;
                $display("FAIL buschg_hold[%0d]: got pulse=%b sync=%h, want 0 3c",
                         k, bus_a.ENABLE_PULSE, bus_a.SYNC_BUS);
            end
        end
        req = 1'b0;
        tick(); tick(); tick(); tick();
        n_checks++;
        if (bus_a.ACK !== 1'b0 || bus_a.SYNC_BUS !== 8'h3C || bus_a.XFER_CNT !== 8'd3) begin
            n_fail++;
            $display("FAIL buschg_end: got ack=%b sync=%h cnt=%0d, want 0 3c 3",
                     bus_a.ACK, bus_a.SYNC_BUS, bus_a.XFER_CNT);
        end
        $display("bus_change: sync=%h cnt=%0d", bus_a.SYNC_BUS, bus_a.XFER_CNT);
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int cyc;
        logic [7:0] d;
        logic [7:0] exp_cnt;
        req = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 258; i++) begin
            d       = 8'(i);
            exp_cnt = 8'(i + 1);
            data    = d;
            req     = 1'b1;
            cyc     = 0;
            while (bus_a.ENABLE_PULSE !== 1'b1 && cyc < 10) begin
                tick();
                cyc++;
            end
            if (bus_a.ENABLE_PULSE === 1'b1) pulses++;
            n_checks++;
            if (bus_a.ENABLE_PULSE !== 1'b1 || cyc != 3 || bus_a.SYNC_BUS !== d || bus_a.XFER_CNT !== exp_cnt) begin
                n_fail++;
                $display("FAIL b2b_capture[%0d]: got pulse=%b after %0d cycles sync=%h cnt=%0d, want 1 after 3 sync=%h cnt=%0d",
                         i, bus_a.ENABLE_PULSE, cyc, bus_a.SYNC_BUS, bus_a.XFER_CNT, d, exp_cnt);
            end
            tick();
            if (bus_a.ENABLE_PULSE === 1'b1) pulses++;
            req = 1'b0;
            cyc = 0;
            while (bus_a.ACK !== 1'b0 && cyc < 10) begin
                tick();
                cyc++;
                if (bus_a.ENABLE_PULSE === 1'b1) pulses++;
            end
            if (bus_a.ACK !== 1'b0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b2b_ack_timeout[%0d]: got ack=%b after %0d cycles, want 0", i, bus_a.ACK, cyc);
            end
        end
        n_checks++;
        if (pulses != 258 || bus_a.XFER_CNT !== 8'd2) begin
            n_fail++;
            $display("FAIL b2b_totals: got pulses=%0d cnt=%0d, want 258 2", pulses, bus_a.XFER_CNT);
        end
        $display("back_to_back: pulses=%0d cnt=%0d", pulses, bus_a.XFER_CNT);
    endtask

    task automatic test_timeout();
        logic exp_err;
        n_checks++;
        if (bus_a.ERR_FLAG !== 1'b0 || bus_b.ERR_FLAG !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_start: got err_a=%b err_b=%b, want 0 0", bus_a.ERR_FLAG, bus_b.ERR_FLAG);
        end
        raise_and_capture(8'h77);
        for (int k = 1; k <= 40; k++) begin
            tick();
            exp_err = (k >= 15);
            n_checks++;
            if (bus_a.ERR_FLAG !== exp_err || bus_b.ERR_FLAG !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_hold[%0d]: got err_a=%b err_b=%b, want %b 0",
                         k, bus_a.ERR_FLAG, bus_b.ERR_FLAG, exp_err);
            end
        end
        req = 1'b0;
        tick(); tick(); tick(); tick();
        n_checks++;
        if (bus_a.ERR_FLAG !== 1'b1 || bus_a.ACK !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_sticky: got err=%b ack=%b, want 1 0", bus_a.ERR_FLAG, bus_a.ACK);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++;
        if (bus_a.ERR_FLAG !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: got err=%b, want 0", bus_a.ERR_FLAG);
        end
        // ERR_CLR held through a second long hold: set must win on the
        // flagging edge, then the clear takes effect one edge later.
        raise_and_capture(8'h88);
        clr = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            exp_err = (k == 15);
            n_checks++;
            if (bus_a.ERR_FLAG !== exp_err || bus_b.ERR_FLAG !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_setwins[%0d]: got err_a=%b err_b=%b, want %b 0",
                         k, bus_a.ERR_FLAG, bus_b.ERR_FLAG, exp_err);
            end
        end
        clr = 1'b0;
        req = 1'b0;
        tick(); tick(); tick(); tick();
        $display("timeout: err_a=%b err_b=%b", bus_a.ERR_FLAG, bus_b.ERR_FLAG);
    endtask

    task automatic test_reset_mid();
        raise_and_capture(8'hC3);
        tick();
        n_checks++;
        if (bus_a.ACK !== 1'b1 || bus_a.SYNC_BUS !== 8'hC3) begin
            n_fail++;
            $display("FAIL midrst_pre: got ack=%b sync=%h, want 1 c3", bus_a.ACK, bus_a.SYNC_BUS);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus_a.ACK !== 1'b0 || bus_a.XFER_CNT !== 8'd0 || bus_a.SYNC_BUS !== 8'h00 || bus_a.ENABLE_PULSE !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_ack: got ack=%b cnt=%0d sync=%h pulse=%b, want 0 0 00 0",
                     bus_a.ACK, bus_a.XFER_CNT, bus_a.SYNC_BUS, bus_a.ENABLE_PULSE);
        end
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus_a.ENABLE_PULSE !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_early: got pulse=%b at edge 1, want 0", bus_a.ENABLE_PULSE);
        end
        tick();
        n_checks++;
        if (bus_a.ENABLE_PULSE !== 1'b1 || bus_a.XFER_CNT !== 8'd1 || bus_a.SYNC_BUS !== 8'hC3 || bus_a.ACK !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_recapture: got pulse=%b cnt=%0d sync=%h ack=%b, want 1 1 c3 1",
                     bus_a.ENABLE_PULSE, bus_a.XFER_CNT, bus_a.SYNC_BUS, bus_a.ACK);
        end
        req = 1'b0;
        tick(); tick(); tick();
        $display("reset_mid: ack=%b cnt=%0d", bus_a.ACK, bus_a.XFER_CNT);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst  = 1'b0;
        req  = 1'b0;
        data = 8'h00;
        clr  = 1'b0;
        test_reset();
        test_single_transfer();
        test_bus_change();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
